// File: rtl/fp_sqrt_pkg.sv
// Shared types and constants for the iterative single-precision square-root unit.
package fp_sqrt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        NORM,
        ITER,
        ROUND,
        DONE
    } state_t;

    localparam logic [31:0] CANON_NAN = 32'h7FC00000;
    localparam logic [31:0] POS_INF   = 32'h7F800000;
    localparam int          BIAS      = 127;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

endpackage

// File: rtl/fp_sqrt_round.sv
// Rounds the 25-bit root (24 significand bits + guard) and packs it into a positive single.
module fp_sqrt_round
    import fp_sqrt_pkg::*;
(
    input  logic [7:0]  i_exp,
    input  logic [24:0] i_root,
    input  logic        i_sticky,
    input  logic [2:0]  i_rm,
    output logic [31:0] o_result,
    output logic        o_nx
);

    logic        w_g;
    logic        w_inc;
    logic [24:0] w_sig;
    logic [7:0]  w_exp;

    assign w_g = i_root[0];

    // The root is never negative, so RDN behaves as RTZ and an exact tie cannot occur.
    always_comb begin
        w_inc = w_g;
        case (i_rm)
            RM_RTZ, RM_RDN: w_inc = 1'b0;
            RM_RUP:         w_inc = w_g | i_sticky;
            default:        w_inc = w_g;
        endcase
    end

    assign w_sig    = {1'b0, i_root[24:1]} + {24'b0, w_inc};
    assign w_exp    = i_exp + {7'b0, w_sig[24]};
    assign o_result = {1'b0, w_exp, (w_sig[24] ? w_sig[23:1] : w_sig[22:0])};
    assign o_nx     = w_g | i_sticky;

endmodule

// File: rtl/fp_sqrt_iter.sv
// Multi-cycle IEEE-754 single sqrt: restoring radix-2 recurrence, one root bit per cycle.
// Define FSQRT_SUBNORM_EN to normalize subnormal operands; otherwise they flush to signed zero.
module fp_sqrt_iter
    import fp_sqrt_pkg::*;
#(
    parameter int ITER_BITS = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        kill,
    input  logic [31:0] a,
    input  logic [2:0]  rm,
    output logic        busy,
    output logic        valid,
    output logic [31:0] result,
    output logic [4:0]  fflags
);

    state_t      r_state;
    logic [31:0] r_a;
    logic [2:0]  r_rm;
    logic [49:0] r_rad;
    logic [26:0] r_rem;
    logic [24:0] r_root;
    logic [4:0]  r_cnt;
    logic [7:0]  r_rexp;
    logic [31:0] r_pres;
    logic [4:0]  r_pflags;
    logic        r_busy;
    logic        r_valid;
    logic [31:0] r_result;
    logic [4:0]  r_fflags;

    logic        w_exp_max;
    logic        w_exp_zero;
    logic        w_frac_zero;
    logic [23:0] w_p_sig;
    logic [8:0]  w_p_exp;
    logic [8:0]  w_esum;
    logic [49:0] w_rad0;
    logic [26:0] w_prem;
    logic [26:0] w_trial;
    logic        w_ge;
    logic [31:0] w_rnd_res;
    logic        w_rnd_nx;

`ifdef FSQRT_SUBNORM_EN
    logic [22:0] r_sig;
    logic [8:0]  r_exp;
    logic [23:0] w_sig_sh;
    assign w_sig_sh = {r_sig, 1'b0};
`endif

    assign w_exp_max   = &r_a[30:23];
    assign w_exp_zero  = ~|r_a[30:23];
    assign w_frac_zero = ~|r_a[22:0];

    // Operand entering the recurrence: straight from the input, or from the normalizer.
    always_comb begin
        w_p_sig = {1'b1, r_a[22:0]};
        w_p_exp = {1'b0, r_a[30:23]};
`ifdef FSQRT_SUBNORM_EN
        if (r_state == NORM) begin
            w_p_sig = w_sig_sh;
            w_p_exp = r_exp - 9'd1;
        end
`endif
    end

    // Biased E+127 is odd exactly when the unbiased exponent is odd; its half is the result exponent.
    assign w_esum  = w_p_exp + 9'(BIAS);
    assign w_rad0  = w_esum[0] ? {w_p_sig, 26'b0} : {1'b0, w_p_sig, 25'b0};

    assign w_prem  = {r_rem[24:0], r_rad[49:48]};
    assign w_trial = {1'b0, r_root[23:0], 2'b01};
    assign w_ge    = (w_prem >= w_trial);

    fp_sqrt_round u_round (
        .i_exp    (r_rexp),
        .i_root   (r_root),
        .i_sticky (|r_rem),
        .i_rm     (r_rm),
        .o_result (w_rnd_res),
        .o_nx     (w_rnd_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_rm     <= '0;
            r_rad    <= '0;
            r_rem    <= '0;
            r_root   <= '0;
            r_cnt    <= '0;
            r_rexp   <= '0;
            r_pres   <= '0;
            r_pflags <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_fflags <= '0;
`ifdef FSQRT_SUBNORM_EN
            r_sig    <= '0;
            r_exp    <= '0;
`endif
        end else if (kill) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_rm    <= rm;
                        r_busy  <= 1'b1;
                        r_state <= UNPACK;
                    end
                end
                UNPACK: begin
                    r_pflags <= '0;
                    r_rad    <= w_rad0;
                    r_rem    <= '0;
                    r_root   <= '0;
                    r_cnt    <= '0;
                    r_rexp   <= w_esum[8:1];
                    if (w_exp_max && !w_frac_zero) begin
                        r_pres          <= CANON_NAN;
                        r_pflags[FF_NV] <= ~r_a[22];
                        r_state         <= DONE;
                    end else if (w_exp_zero && w_frac_zero) begin
                        r_pres  <= {r_a[31], 31'b0};
                        r_state <= DONE;
`ifndef FSQRT_SUBNORM_EN
                    end else if (w_exp_zero) begin
                        r_pres  <= {r_a[31], 31'b0};
                        r_state <= DONE;
`endif
                    end else if (r_a[31]) begin
                        r_pres          <= CANON_NAN;
                        r_pflags[FF_NV] <= 1'b1;
                        r_state         <= DONE;
                    end else if (w_exp_max) begin
                        r_pres  <= POS_INF;
                        r_state <= DONE;
`ifdef FSQRT_SUBNORM_EN
                    end else if (w_exp_zero) begin
                        r_sig   <= r_a[22:0];
                        r_exp   <= 9'd1;
                        r_state <= NORM;
`endif
                    end else begin
                        r_state <= ITER;
                    end
                end
`ifdef FSQRT_SUBNORM_EN
                NORM: begin
                    r_sig <= w_sig_sh[22:0];
                    r_exp <= r_exp - 9'd1;
                    if (w_sig_sh[23]) begin
                        r_rad   <= w_rad0;
                        r_rexp  <= w_esum[8:1];
                        r_state <= ITER;
                    end
                end
`endif
                ITER: begin
                    r_rem   <= w_ge ? (w_prem - w_trial) : w_prem;
                    r_root  <= {r_root[23:0], w_ge};
                    r_rad   <= {r_rad[47:0], 2'b00};
                    r_cnt   <= r_cnt + 5'd1;
                    if (r_cnt == 5'(ITER_BITS - 1))
                        r_state <= ROUND;
                end
                ROUND: begin
                    r_pres   <= w_rnd_res;
                    r_pflags <= {4'b0, w_rnd_nx};
                    r_state  <= DONE;
                end
                DONE: begin
                    r_result <= r_pres;
                    r_fflags <= r_pflags;
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign valid  = r_valid;
    assign result = r_result;
    assign fflags = r_fflags;

endmodule

// File: doc/fp_sqrt_iter.md
Name: fp_sqrt_iter

Overview:
Multi-cycle IEEE-754 single-precision square-root unit for the rv32imf FPU, placed in the block_sqrt group next to the FP adder. It unpacks the operand, normalizes subnormals, and runs a restoring radix-2 digit recurrence that yields one root bit per cycle. It then rounds and packs the result. It sits behind a start/valid handshake so the FPU issue logic can stall on busy.

Parameters:
ITER_BITS, 25, root bits generated: 24 significand bits plus a guard bit. Sticky is taken from remainder != 0.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
start  in  1  launch request; accepted only in IDLE
kill  in  1  synchronous abort (pipeline flush); returns to IDLE, no valid pulse
a  in  32  operand, sampled on the accepted start
rm  in  3  rounding mode, sampled on the accepted start (already resolved from frm upstream)
busy  out  1  high from the cycle after an accepted start until valid
valid  out  1  one-cycle pulse, result and fflags are meaningful
result  out  32  packed root, held until the next accepted start
fflags  out  5  {NV,DZ,OF,UF,NX}; DZ, OF and UF are always 0

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, datapath registers 0.
- rst or kill mid-operation: IDLE on the next edge, busy=0, no valid pulse; rst wins over start in the same cycle.
- start while busy is ignored. start in the same cycle as valid is accepted, because DONE returns to IDLE combinationally for acceptance.
- States and transitions:
  - IDLE --start--> UNPACK
  - UNPACK --special--> DONE; UNPACK --subnormal--> NORM; UNPACK --otherwise--> ITER
  - NORM shifts the significand left 1 bit per cycle until bit 23 = 1, decrementing the exponent; k = shift count
  - ITER runs ITER_BITS cycles, then goes to ROUND
  - ROUND takes 1 cycle, then goes to DONE
  - DONE asserts valid for 1 cycle, then goes to IDLE
- Latency, counted from the start edge to valid high:
  - finite positive normal: 28 cycles
  - subnormal: 28+k cycles
  - special: 2 cycles
- Special cases, resolved in UNPACK:
  - any NaN -> 0x7FC00000; NV only for sNaN (mantissa bit 22 = 0)
  - negative nonzero, including -inf -> 0x7FC00000, NV
  - ±0 -> ±0, no flags
  - +inf -> +inf, no flags
- Exponent rule:
  - unbiased e = exp-127; subnormal e = -126-k
  - if e is odd, shift the significand left 1 and use e-1
  - result exponent = e/2 + 127; always normal, so OF and UF are never set
- Datapath widths: radicand 50 bits (significand padded with zeros), remainder 27 bits, root 25 bits.
- Rounding (G = root LSB, S = remainder != 0; an exact tie is impossible for sqrt):
  - RNE (000) and RMM (100): increment if G
  - RTZ (001) and RDN (010): truncate, since the result is positive
  - RUP (011): increment if G|S
  - codes 101, 110, 111: treated as RNE
  - mantissa carry-out increments the exponent
  - NX = G|S

Optional Feature:
FSQRT_SUBNORM_EN
- Defined: subnormal inputs are normalized in NORM, giving full IEEE results.
- Undefined: the NORM state is omitted. A subnormal input is flushed to a same-sign zero with 2-cycle latency and no flags.

Decomposition:
- Package fp_sqrt_pkg holds:
  - state enum (IDLE, UNPACK, NORM, ITER, ROUND, DONE)
  - CANON_NAN = 32'h7FC00000, BIAS = 127
  - rm encodings (RNE, RTZ, RDN, RUP, RMM)
  - fflags bit indices
- One sub-module, fp_sqrt_round: combinational rounding and packing of {exp, root, S, rm} into {result, NX}. It is instantiated once.

Test Plan:
1. a=0x40800000 (4.0), rm=000 -> result 0x40000000, fflags 0, valid exactly 28 cycles after start, busy high throughout.
2. a=0x40000000 (2.0) -> rm=000: 0x3FB504F3, NX; rm=001: 0x3FB504F3; rm=011: 0x3FB504F4, NX.
3. a=0xC0800000 -> 0x7FC00000, fflags 5'b10000, 2-cycle latency. a=0x80000000 -> 0x80000000, flags 0. a=0x7F800001 -> 0x7FC00000, NV.
4. a=0x00000001, rm=000:
   - with FSQRT_SUBNORM_EN: 0x1A3504F3, NX, latency 51 cycles (k=23)
   - without it: 0x00000000, flags 0, latency 2 cycles
5. Start with a=2.0, then assert rst at cycle 10 -> busy=0 on the next edge, no valid pulse. Repeat the abort with kill. A new start with 4.0 afterwards -> 0x40000000.
6. Second start pulsed at cycle 5 while busy -> ignored, one valid pulse only. Start in the same cycle as valid -> accepted, second result correct.
